// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage.
// Issues one data-memory access at a time over a req/ack handshake, formats
// load data, builds store strobes and registers the MEM->WB latch.
// Optional feature macro: MEM_MISALIGN_EN (misaligned accesses fault to WB
// instead of going to memory).
module memory_stage #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned DMEM_BYTES = 8
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            MEM_V,
    input  logic [31:0]     MEM_IR,
    input  logic [XLEN-1:0] MEM_NPC,
    input  logic [XLEN-1:0] MEM_ALU_RESULT,
    input  logic [XLEN-1:0] MEM_SR2,
    input  logic [XLEN-1:0] MEM_CSRFD,
    input  logic [XLEN-1:0] MEM_RFD,
    input  logic            MEM_ECALL,
    output logic            V_MEM_STALL,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [XLEN-1:0] DMEM_WDATA,
    output logic [7:0]      DMEM_WSTRB,
    input  logic [XLEN-1:0] DMEM_RDATA,
    input  logic            DMEM_ACK,
    output logic            WB_V,
    output logic            WB_ECALL,
    output logic            WB_MISALIGN,
    output logic [31:0]     WB_IR,
    output logic [XLEN-1:0] WB_NPC,
    output logic [XLEN-1:0] WB_DATA,
    output logic [XLEN-1:0] WB_CSRFD,
    output logic [XLEN-1:0] WB_RFD
);

    localparam int unsigned OFF_W    = $clog2(DMEM_BYTES);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [31:0]       cap_ir;
    logic [XLEN-1:0]   cap_npc;
    logic [XLEN-1:0]   cap_addr;
    logic [XLEN-1:0]   cap_csrfd;
    logic [XLEN-1:0]   cap_rfd;
    logic              cap_ecall;

    logic              is_load;
    logic              is_store;
    logic              memop;
    logic              misalign_c;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic [7:0]        strb_base;
    logic [7:0]        store_strb;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   pass_data;
    logic [OFF_W-1:0]  cap_off;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_data;

    assign is_load  = (MEM_IR[6:0] == OP_LOAD);
    assign is_store = (MEM_IR[6:0] == OP_STORE);
    assign memop    = MEM_V && (is_load || is_store);
    assign in_off   = MEM_ALU_RESULT[OFF_W-1:0];
    assign in_size  = MEM_IR[13:12];

`ifdef MEM_MISALIGN_EN
    // Natural alignment check by access size
    always_comb begin
        misalign_c = 1'b0;
        case (in_size)
            2'd1:    misalign_c = memop && in_off[0];
            2'd2:    misalign_c = memop && (|in_off[1:0]);
            2'd3:    misalign_c = memop && (|in_off);
            default: misalign_c = 1'b0;
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Hold execute while an access is being issued or awaiting its ack
    assign V_MEM_STALL = ((state == S_IDLE) && memop && !misalign_c) ||
                         ((state == S_WAIT) && !DMEM_ACK);

    // Store lane placement: strobes and data shifted to the byte offset
    always_comb begin
        strb_base = 8'h00;
        case (in_size)
            2'd0: strb_base = 8'h01;
            2'd1: strb_base = 8'h03;
            2'd2: strb_base = 8'h0F;
            2'd3: strb_base = 8'hFF;
            default: strb_base = 8'h00;
        endcase
        store_strb = 8'(strb_base << in_off);
        store_data = MEM_SR2 << {in_off, 3'b000};
        pass_data  = ((MEM_IR[6:0] == OP_JAL) || (MEM_IR[6:0] == OP_JALR)) ?
                     MEM_NPC : MEM_ALU_RESULT;
    end

    // Load formatting from the captured address offset and funct3
    always_comb begin
        cap_off  = cap_addr[OFF_W-1:0];
        ld_shift = DMEM_RDATA >> {cap_off, 3'b000};
        ld_data  = '0;
        case (cap_ir[14:12])
            3'd0: ld_data = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            3'd1: ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'd2: ld_data = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            3'd3: ld_data = ld_shift;
            3'd4: ld_data = {{(XLEN-8){1'b0}},  ld_shift[7:0]};
            3'd5: ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            3'd6: ld_data = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
            default: ld_data = '0;
        endcase
    end

    // Stage FSM: request issue, ack wait and WB latch update
    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= S_IDLE;
            cap_ir      <= '0;
            cap_npc     <= '0;
            cap_addr    <= '0;
            cap_csrfd   <= '0;
            cap_rfd     <= '0;
            cap_ecall   <= 1'b0;
            DMEM_REQ    <= 1'b0;
            DMEM_WE     <= 1'b0;
            DMEM_ADDR   <= '0;
            DMEM_WDATA  <= '0;
            DMEM_WSTRB  <= '0;
            WB_V        <= 1'b0;
            WB_ECALL    <= 1'b0;
            WB_MISALIGN <= 1'b0;
            WB_IR       <= '0;
            WB_NPC      <= '0;
            WB_DATA     <= '0;
            WB_CSRFD    <= '0;
            WB_RFD      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop && misalign_c) begin
                        WB_V        <= 1'b1;
                        WB_MISALIGN <= 1'b1;
                        WB_ECALL    <= MEM_ECALL;
                        WB_IR       <= MEM_IR;
                        WB_NPC      <= MEM_NPC;
                        WB_DATA     <= MEM_ALU_RESULT;
                        WB_CSRFD    <= MEM_CSRFD;
                        WB_RFD      <= MEM_RFD;
                    end else if (memop) begin
                        state       <= S_WAIT;
                        cap_ir      <= MEM_IR;
                        cap_npc     <= MEM_NPC;
                        cap_addr    <= MEM_ALU_RESULT;
                        cap_csrfd   <= MEM_CSRFD;
                        cap_rfd     <= MEM_RFD;
                        cap_ecall   <= MEM_ECALL;
                        DMEM_REQ    <= 1'b1;
                        DMEM_WE     <= is_store;
                        DMEM_ADDR   <= {MEM_ALU_RESULT[XLEN-1:OFF_W], OFF_W'(0)};
                        DMEM_WDATA  <= is_store ? store_data : '0;
                        DMEM_WSTRB  <= is_store ? store_strb : 8'h00;
                        WB_V        <= 1'b0;
                        WB_ECALL    <= 1'b0;
                        WB_MISALIGN <= 1'b0;
                        WB_IR       <= '0;
                        WB_NPC      <= '0;
                        WB_DATA     <= '0;
                        WB_CSRFD    <= '0;
                        WB_RFD      <= '0;
                    end else begin
                        WB_V        <= MEM_V;
                        WB_MISALIGN <= 1'b0;
                        WB_ECALL    <= MEM_V ? MEM_ECALL : 1'b0;
                        WB_IR       <= MEM_V ? MEM_IR    : '0;
                        WB_NPC      <= MEM_V ? MEM_NPC   : '0;
                        WB_DATA     <= MEM_V ? pass_data : '0;
                        WB_CSRFD    <= MEM_V ? MEM_CSRFD : '0;
                        WB_RFD      <= MEM_V ? MEM_RFD   : '0;
                    end
                end
                S_WAIT: begin
                    if (DMEM_ACK) begin
                        state       <= S_IDLE;
                        DMEM_REQ    <= 1'b0;
                        DMEM_WE     <= 1'b0;
                        DMEM_ADDR   <= '0;
                        DMEM_WDATA  <= '0;
                        DMEM_WSTRB  <= 8'h00;
                        WB_V        <= 1'b1;
                        WB_MISALIGN <= 1'b0;
                        WB_ECALL    <= cap_ecall;
                        WB_IR       <= cap_ir;
                        WB_NPC      <= cap_npc;
                        WB_DATA     <= (cap_ir[6:0] == OP_LOAD) ? ld_data : '0;
                        WB_CSRFD    <= cap_csrfd;
                        WB_RFD      <= cap_rfd;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage with hand-computed expectations.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        RESET;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
    logic        MEM_ECALL;
    logic        V_MEM_STALL;
    logic        DMEM_REQ, DMEM_WE;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [7:0]  DMEM_WSTRB;
    logic        DMEM_ACK;
    logic        WB_V, WB_ECALL, WB_MISALIGN;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC, WB_DATA, WB_CSRFD, WB_RFD;

    int checks   = 0;
    int failures = 0;

    // First-WAIT-cycle request snapshot and stall count from mem_access
    logic        r_req, r_we;
    logic [63:0] r_addr, r_wdata;
    logic [7:0]  r_wstrb;
    int          stalls;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .RESET(RESET),
        .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2),
        .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL),
        .V_MEM_STALL(V_MEM_STALL),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
        .WB_V(WB_V), .WB_ECALL(WB_ECALL), .WB_MISALIGN(WB_MISALIGN),
        .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_DATA(WB_DATA),
        .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a memop, bubble the latch, ack after 'delay' wait cycles; returns just after WB update
    task automatic mem_access(input logic [31:0] ir, input logic [63:0] addr,
                              input logic [63:0] sr2, input logic [63:0] rdata,
                              input int delay);
        MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RESULT = addr; MEM_SR2 = sr2;
        MEM_NPC = 64'h500;
        #1;
        stalls = V_MEM_STALL ? 1 : 0;
        tick();
        MEM_V = 1'b0;
        #1;
        r_req = DMEM_REQ; r_we = DMEM_WE; r_addr = DMEM_ADDR;
        r_wdata = DMEM_WDATA; r_wstrb = DMEM_WSTRB;
        for (int i = 1; i <= delay; i++) begin
            if (V_MEM_STALL) stalls++;
            tick();
        end
        DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
        #1;
        if (V_MEM_STALL) stalls++;
        tick();
        DMEM_ACK = 1'b0; DMEM_RDATA = '0;
    endtask

    initial begin
        RESET = 1'b1; MEM_V = 1'b0; MEM_IR = '0; MEM_NPC = '0; MEM_ALU_RESULT = '0;
        MEM_SR2 = '0; MEM_CSRFD = '0; MEM_RFD = '0; MEM_ECALL = 1'b0;
        DMEM_RDATA = '0; DMEM_ACK = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        #1;
        check("rst_wb_v",  64'(WB_V), 64'd0);
        check("rst_req",   64'(DMEM_REQ), 64'd0);
        check("rst_stall", 64'(V_MEM_STALL), 64'd0);
        check("rst_wbdat", WB_DATA, 64'd0);

        // ADD pass-through
        MEM_V = 1'b1; MEM_IR = mk_ir(3'd0, OP_ALU); MEM_ALU_RESULT = 64'h1234;
        MEM_NPC = 64'h104; MEM_CSRFD = 64'h77;
        #1;
        check("add_stall", 64'(V_MEM_STALL), 64'd0);
        tick();
        MEM_V = 1'b0;
        check("add_wb_v",  64'(WB_V), 64'd1);
        check("add_data",  WB_DATA, 64'h1234);
        check("add_csrfd", WB_CSRFD, 64'h77);
        check("add_req",   64'(DMEM_REQ), 64'd0);
        tick();
        check("idle_wb_v", 64'(WB_V), 64'd0);

        // LB at 0x1003, ack 3 cycles after request
        mem_access(mk_ir(3'd0, OP_LOAD), 64'h1003, 64'd0, 64'h00000000_80FF0000, 3);
        check("lb_req",    64'(r_req), 64'd1);
        check("lb_we",     64'(r_we), 64'd0);
        check("lb_addr",   r_addr, 64'h1000);
        check("lb_stalls", 64'(stalls), 64'd4);
        check("lb_wb_v",   64'(WB_V), 64'd1);
        check("lb_data",   WB_DATA, 64'hFFFFFFFF_FFFFFF80);
        check("lb_npc",    WB_NPC, 64'h500);
        check("lb_req_dn", 64'(DMEM_REQ), 64'd0);

        // LBU same access
        mem_access(mk_ir(3'd4, OP_LOAD), 64'h1003, 64'd0, 64'h00000000_80FF0000, 3);
        check("lbu_data",  WB_DATA, 64'h80);

        // SH at 0x2006
        mem_access(mk_ir(3'd1, OP_STORE), 64'h2006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        check("sh_we",     64'(r_we), 64'd1);
        check("sh_strb",   64'(r_wstrb), 64'hC0);
        check("sh_wdata",  r_wdata, 64'hABCD_0000_0000_0000);
        check("sh_addr",   r_addr, 64'h2000);
        check("sh_wb_v",   64'(WB_V), 64'd1);
        check("sh_data",   WB_DATA, 64'd0);

        // JAL returns NPC
        MEM_V = 1'b1; MEM_IR = mk_ir(3'd0, OP_JAL); MEM_NPC = 64'h408; MEM_ALU_RESULT = 64'h999;
        tick();
        MEM_V = 1'b0;
        check("jal_data",  WB_DATA, 64'h408);

        // LD then ADD back-to-back
        mem_access(mk_ir(3'd3, OP_LOAD), 64'h1008, 64'd0, 64'h11223344_55667788, 1);
        check("ld_data",   WB_DATA, 64'h11223344_55667788);
        MEM_V = 1'b1; MEM_IR = mk_ir(3'd0, OP_ALU); MEM_ALU_RESULT = 64'h55;
        tick();
        MEM_V = 1'b0;
        check("b2b_wb_v",  64'(WB_V), 64'd1);
        check("b2b_data",  WB_DATA, 64'h55);

        // LW at offset 4 sign-extends the upper word
        mem_access(mk_ir(3'd2, OP_LOAD), 64'h1004, 64'd0, 64'h80000000_00000000, 0);
        check("lw4_data",  WB_DATA, 64'hFFFFFFFF_80000000);

        // funct3=7 load gives zero
        mem_access(mk_ir(3'd7, OP_LOAD), 64'h1000, 64'd0, 64'hDEAD_BEEF_DEAD_BEEF, 1);
        check("f3_7_data", WB_DATA, 64'd0);

`ifdef MEM_MISALIGN_EN
        // Misaligned LW faults without a memory access
        MEM_V = 1'b1; MEM_IR = mk_ir(3'd2, OP_LOAD); MEM_ALU_RESULT = 64'h3002;
        #1;
        check("mis_stall", 64'(V_MEM_STALL), 64'd0);
        tick();
        MEM_V = 1'b0;
        check("mis_req",   64'(DMEM_REQ), 64'd0);
        check("mis_wb_v",  64'(WB_V), 64'd1);
        check("mis_flag",  64'(WB_MISALIGN), 64'd1);
        check("mis_data",  WB_DATA, 64'h3002);
`else
        // Misaligned LW uses lane shift only
        mem_access(mk_ir(3'd2, OP_LOAD), 64'h3002, 64'd0, 64'h89ABCDEF_01234567, 1);
        check("mis_req",   64'(r_req), 64'd1);
        check("mis_flag",  64'(WB_MISALIGN), 64'd0);
        check("mis_data",  WB_DATA, 64'hFFFFFFFF_CDEF0123);
`endif

        // Reset while waiting aborts the access; a late ack is ignored
        MEM_V = 1'b1; MEM_IR = mk_ir(3'd3, OP_LOAD); MEM_ALU_RESULT = 64'h1000;
        tick();
        MEM_V = 1'b0;
        check("rw_req_up", 64'(DMEM_REQ), 64'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rw_req",    64'(DMEM_REQ), 64'd0);
        check("rw_wb_v",   64'(WB_V), 64'd0);
        tick();
        DMEM_ACK = 1'b1; DMEM_RDATA = 64'h1234_5678;
        #1;
        check("rw_stall",  64'(V_MEM_STALL), 64'd0);
        tick();
        DMEM_ACK = 1'b0;
        check("rw_late",   64'(WB_V), 64'd0);
        tick();
        check("rw_late2",  64'(WB_V), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
